// File: rtl/perceptron_bram_portb_arbiter.sv
// Round-robin burst arbiter sharing BRAM port B between the MAC fetch engine (0) and writeback (1).
// Define PERCEPTRON_BRAM_OUT_REG_EN when the BRAM is built with its output register (read latency 2).
module perceptron_bram_portb_arbiter #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned LEN_W  = 8
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_aresetn,
  input  logic              req0,
  input  logic              req1,
  input  logic              rw0,
  input  logic              rw1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [LEN_W-1:0]  len0,
  input  logic [LEN_W-1:0]  len1,
  input  logic [31:0]       wdata0,
  input  logic [31:0]       wdata1,
  input  logic [3:0]        wstrb0,
  input  logic [3:0]        wstrb1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              wready0,
  output logic              wready1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [31:0]       rdata,
  output logic              done0,
  output logic              done1,
  output logic              bram_en,
  output logic [3:0]        bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [31:0]       bram_din,
  input  logic [31:0]       bram_dout
);

`ifdef PERCEPTRON_BRAM_OUT_REG_EN
  localparam int unsigned RD_LAT = 2;
`else
  localparam int unsigned RD_LAT = 1;
`endif

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]        state, state_n;
  logic              owner, owner_n;
  logic              rw_q, rw_n;
  logic [LEN_W-1:0]  len_q, len_n;
  logic [LEN_W-1:0]  cnt, cnt_n;
  logic              dcnt, dcnt_n;
  logic              last_served, last_n;
  logic              rd_issue, rd_issue_n;
  logic              issue;
  logic              win_c;

  logic              gnt0_n, gnt1_n, wready0_n, wready1_n, done0_n, done1_n;
  logic              en_n;
  logic [3:0]        we_n;
  logic [ADDR_W-1:0] addr_n;
  logic [31:0]       din_n;

  logic              vld_c;
  logic              own_c;

  // Tie goes to the requester not served last; otherwise the single requester.
  assign win_c = (req0 && req1) ? ~last_served : req1;

  assign rdata = bram_dout;

  // Next-state and next-output logic; every beat is registered onto port B.
  always_comb begin
    state_n    = state;
    owner_n    = owner;
    rw_n       = rw_q;
    len_n      = len_q;
    cnt_n      = cnt;
    dcnt_n     = dcnt;
    last_n     = last_served;
    issue      = 1'b0;
    gnt0_n     = 1'b0;
    gnt1_n     = 1'b0;
    wready0_n  = 1'b0;
    wready1_n  = 1'b0;
    done0_n    = 1'b0;
    done1_n    = 1'b0;
    en_n       = 1'b0;
    we_n       = 4'h0;
    addr_n     = bram_addr;
    din_n      = bram_din;
    rd_issue_n = 1'b0;

    case (state)
      ST_IDLE: begin
        if (req0 || req1) begin
          owner_n = win_c;
          rw_n    = win_c ? rw1 : rw0;
          len_n   = win_c ? len1 : len0;
          addr_n  = win_c ? addr1 : addr0;
          last_n  = win_c;
          cnt_n   = '0;
          dcnt_n  = 1'b0;
          gnt0_n  = ~win_c;
          gnt1_n  = win_c;
          issue   = 1'b1;
          state_n = (len_n == '0) ? ST_DRAIN : ST_BURST;
        end
      end
      ST_BURST: begin
        issue  = 1'b1;
        addr_n = bram_addr + ADDR_W'(1);
        cnt_n  = cnt + LEN_W'(1);
        if (cnt_n == len_q) state_n = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Writes finish one cycle after the last beat; reads wait for the last rvalid.
        if (rw_q || (dcnt == 1'(RD_LAT - 1))) begin
          done0_n = ~owner;
          done1_n = owner;
          state_n = ST_IDLE;
        end else begin
          dcnt_n = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (issue) begin
      en_n       = 1'b1;
      rd_issue_n = ~rw_n;
      if (rw_n) begin
        we_n      = owner_n ? wstrb1 : wstrb0;
        din_n     = owner_n ? wdata1 : wdata0;
        wready0_n = ~owner_n;
        wready1_n = owner_n;
      end
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state       <= ST_IDLE;
      owner       <= 1'b0;
      rw_q        <= 1'b0;
      len_q       <= '0;
      cnt         <= '0;
      dcnt        <= 1'b0;
      last_served <= 1'b1;
      rd_issue    <= 1'b0;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      wready0     <= 1'b0;
      wready1     <= 1'b0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      bram_en     <= 1'b0;
      bram_we     <= 4'h0;
      bram_addr   <= '0;
      bram_din    <= 32'h0;
    end else begin
      state       <= state_n;
      owner       <= owner_n;
      rw_q        <= rw_n;
      len_q       <= len_n;
      cnt         <= cnt_n;
      dcnt        <= dcnt_n;
      last_served <= last_n;
      rd_issue    <= rd_issue_n;
      gnt0        <= gnt0_n;
      gnt1        <= gnt1_n;
      wready0     <= wready0_n;
      wready1     <= wready1_n;
      done0       <= done0_n;
      done1       <= done1_n;
      bram_en     <= en_n;
      bram_we     <= we_n;
      bram_addr   <= addr_n;
      bram_din    <= din_n;
    end
  end

`ifdef PERCEPTRON_BRAM_OUT_REG_EN
  logic pipe_v;
  logic pipe_o;

  // Extra stage matching the BRAM output register.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      pipe_v <= 1'b0;
      pipe_o <= 1'b0;
    end else begin
      pipe_v <= rd_issue;
      pipe_o <= owner;
    end
  end

  assign vld_c = pipe_v;
  assign own_c = pipe_o;
`else
  assign vld_c = rd_issue;
  assign own_c = owner;
`endif

  // Final valid stage, steered to the owner of the beat.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid0 <= vld_c & ~own_c;
      rvalid1 <= vld_c & own_c;
    end
  end

endmodule
